mips_instr_encoder: RTL and testbench

Command-to-instruction encoder for the P4 single-cycle MIPS datapath, the opposite end of the `control` decoder. Accepts abstract commands (operation code plus register/immediate fields) over a valid/ready handshake and emits 32-bit MIPS instruction words, with `op`/`fun` broken out, through a small FIFO. The block drives the decoder and the instruction-memory preload path in benches, and expands the `li` pseudo-instruction into two words.

---
 rtl/mips_isa_pkg.sv | 57 +++++
 rtl/mips_instr_encoder_if.sv | 33 +++
 rtl/instr_fifo.sv | 59 +++++
 rtl/mips_instr_encoder.sv | 157 +++++++++++++++
 tb/tb_mips_instr_encoder.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants: opcodes, functs, encoder command codes, encoder FSM states.
// Latency: none (declarations and pure field-packing helpers only).
// Backpressure: not applicable.
package mips_isa_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FUN_JR   = 6'h08;
  localparam logic [5:0] FUN_ADDU = 6'h21;
  localparam logic [5:0] FUN_SUBU = 6'h23;

  // Abstract command codes accepted by the encoder; 12..15 are illegal
  typedef enum logic [3:0] {
    CMD_NOP  = 4'd0,
    CMD_ADDU = 4'd1,
    CMD_SUBU = 4'd2,
    CMD_ORI  = 4'd3,
    CMD_LW   = 4'd4,
    CMD_SW   = 4'd5,
    CMD_BEQ  = 4'd6,
    CMD_LUI  = 4'd7,
    CMD_J    = 4'd8,
    CMD_JAL  = 4'd9,
    CMD_JR   = 4'd10,
    CMD_LI   = 4'd11
  } cmd_code_e;

  // Encoder FSM: LI_LO holds the pending ORI half of an LI expansion
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_LI_LO = 1'b1
  } enc_state_e;

  function automatic logic [31:0] r_type(logic [4:0] rs, logic [4:0] rt,
                                         logic [4:0] rd, logic [5:0] fun);
    return {OP_RTYPE, rs, rt, rd, 5'd0, fun};
  endfunction

  function automatic logic [31:0] i_type(logic [5:0] op, logic [4:0] rs,
                                         logic [4:0] rt, logic [15:0] imm16);
    return {op, rs, rt, imm16};
  endfunction

  function automatic logic [31:0] j_type(logic [5:0] op, logic [25:0] imm26);
    return {op, imm26};
  endfunction

endpackage

// File: rtl/mips_instr_encoder_if.sv
// Command-in / instruction-out bundle of the MIPS instruction encoder.
// Latency: none (wires only).
// Backpressure: cmd_valid/cmd_ready on the command side, instr_valid/instr_ready on the output side.
interface mips_instr_encoder_if #(parameter int DEPTH = 4);

  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [3:0]               cmd_code;
  logic [4:0]               cmd_rs;
  logic [4:0]               cmd_rt;
  logic [4:0]               cmd_rd;
  logic [31:0]              cmd_imm;
  logic                     instr_valid;
  logic                     instr_ready;
  logic [31:0]              instr;
  logic [5:0]               op;
  logic [5:0]               fun;
  logic [$clog2(DEPTH):0]   count;
  logic                     err;

  // Command producer / instruction consumer side
  modport master (
    output cmd_valid, cmd_code, cmd_rs, cmd_rt, cmd_rd, cmd_imm, instr_ready,
    input  cmd_ready, instr_valid, instr, op, fun, count, err
  );

  // Encoder side
  modport slave (
    input  cmd_valid, cmd_code, cmd_rs, cmd_rt, cmd_rd, cmd_imm, instr_ready,
    output cmd_ready, instr_valid, instr, op, fun, count, err
  );

endinterface

// File: rtl/instr_fifo.sv
// Generic 32-bit FIFO, DEPTH entries (power of two), occupancy counter.
// Latency: a word pushed in cycle N is visible at the head in cycle N+1.
// Backpressure: pushes while full are dropped (callers gate on full_o); pops while empty are ignored.
module instr_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [31:0]            push_dat_i,
  input  logic                   pop_i,
  output logic [31:0]            pop_dat_o,
  output logic                   vld_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] count_q;
  logic          push_ok;
  logic          pop_ok;

  assign full_o    = (count_q == CW'(DEPTH));
  assign vld_o     = (count_q != '0);
  assign count_o   = count_q;
  assign push_ok   = push_i && !full_o;
  assign pop_ok    = pop_i && vld_o;
  assign pop_dat_o = vld_o ? mem_q[rptr_q] : '0;

  // Storage write; contents need no reset since count_q qualifies them
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= push_dat_i;
    end
  end

  // Pointers wrap naturally modulo DEPTH; count_q disambiguates full/empty
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop_ok)  rptr_q <= rptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Encodes abstract commands into MIPS instruction words into an output FIFO; ENCODER_LI_EN adds LI -> LUI+ORI expansion.
// Latency: accepted command's word at the FIFO head one cycle later (empty FIFO); LI's ORI half follows one cycle after LUI.
// Backpressure: cmd_ready depends only on registered state (FIFO not full, no pending LI half); no path from instr_ready.
module mips_instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_instr_encoder_if.slave   enc
);

`ifdef ENCODER_LI_EN
  localparam logic [3:0] LAST_LEGAL = CMD_LI;
`else
  localparam logic [3:0] LAST_LEGAL = CMD_JR;
`endif

  logic                   push;
  logic [31:0]            push_dat;
  logic [31:0]            head;
  logic                   head_vld;
  logic                   full;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   err_q, err_d;
  logic                   accept;
  logic                   legal;
  cmd_code_e              code;

  function automatic logic [31:0] encode(cmd_code_e c, logic [4:0] rs, logic [4:0] rt,
                                         logic [4:0] rd, logic [25:0] imm);
    logic [31:0] w;
    w = '0;
    case (c)
      CMD_ADDU: w = r_type(rs, rt, rd, FUN_ADDU);
      CMD_SUBU: w = r_type(rs, rt, rd, FUN_SUBU);
      CMD_ORI:  w = i_type(OP_ORI, rs, rt, imm[15:0]);
      CMD_LW:   w = i_type(OP_LW,  rs, rt, imm[15:0]);
      CMD_SW:   w = i_type(OP_SW,  rs, rt, imm[15:0]);
      CMD_BEQ:  w = i_type(OP_BEQ, rs, rt, imm[15:0]);
      CMD_LUI:  w = i_type(OP_LUI, 5'd0, rt, imm[15:0]);
      CMD_J:    w = j_type(OP_J,   imm);
      CMD_JAL:  w = j_type(OP_JAL, imm);
      CMD_JR:   w = r_type(rs, 5'd0, 5'd0, FUN_JR);
      default:  w = '0;  // NOP encodes as all zeros
    endcase
    return w;
  endfunction

  assign code   = cmd_code_e'(enc.cmd_code);
  assign legal  = (enc.cmd_code <= LAST_LEGAL);
  assign accept = enc.cmd_valid && enc.cmd_ready;

`ifdef ENCODER_LI_EN
  enc_state_e  state_q, state_d;
  logic [4:0]  li_rt_q, li_rt_d;
  logic [15:0] li_imm_q, li_imm_d;

  assign enc.cmd_ready = (state_q == ST_IDLE) && !full;

  // Next state, push selection and LI latch; LUI goes out on accept, ORI once space exists
  always_comb begin
    state_d  = state_q;
    li_rt_d  = li_rt_q;
    li_imm_d = li_imm_q;
    err_d    = err_q;
    push     = 1'b0;
    push_dat = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (code == CMD_LI) begin
            push     = 1'b1;
            push_dat = i_type(OP_LUI, 5'd0, enc.cmd_rt, enc.cmd_imm[31:16]);
            li_rt_d  = enc.cmd_rt;
            li_imm_d = enc.cmd_imm[15:0];
            state_d  = ST_LI_LO;
          end else if (legal) begin
            push     = 1'b1;
            push_dat = encode(code, enc.cmd_rs, enc.cmd_rt, enc.cmd_rd, enc.cmd_imm[25:0]);
          end else begin
            err_d    = 1'b1;
          end
        end
      end
      ST_LI_LO: begin
        if (!full) begin
          push     = 1'b1;
          push_dat = i_type(OP_ORI, li_rt_q, li_rt_q, li_imm_q);
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and LI latch registers; reset drops any pending ORI half
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      li_rt_q  <= '0;
      li_imm_q <= '0;
    end else begin
      state_q  <= state_d;
      li_rt_q  <= li_rt_d;
      li_imm_q <= li_imm_d;
    end
  end
`else
  logic unused_imm_hi;

  assign unused_imm_hi = ^enc.cmd_imm[31:26];
  assign enc.cmd_ready = !full;

  // Single-word encode on accept; illegal codes (LI included) only raise err
  always_comb begin
    err_d    = err_q;
    push     = 1'b0;
    push_dat = '0;
    if (accept) begin
      if (legal) begin
        push     = 1'b1;
        push_dat = encode(code, enc.cmd_rs, enc.cmd_rt, enc.cmd_rd, enc.cmd_imm[25:0]);
      end else begin
        err_d    = 1'b1;
      end
    end
  end
`endif

  // Sticky illegal-command flag
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (enc.instr_ready),
    .pop_dat_o  (head),
    .vld_o      (head_vld),
    .full_o     (full),
    .count_o    (fifo_count)
  );

  assign enc.instr       = head;
  assign enc.op          = head[31:26];
  assign enc.fun         = head[5:0];
  assign enc.instr_valid = head_vld;
  assign enc.count       = fifo_count;
  assign enc.err         = err_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder: directed scenarios plus randomized traffic vs a queue model.
// Latency: outputs checked on the falling edge after each rising edge.
// Backpressure: instr_ready is driven randomly/directed; model predicts cmd_ready.
module tb_mips_instr_encoder;

  localparam int DEPTH = 4;
  localparam int unsigned P26 = 32'h0400_0000;
  localparam int unsigned P21 = 32'h0020_0000;
  localparam int unsigned P16 = 32'h0001_0000;
  localparam int unsigned P11 = 32'h0000_0800;

`ifdef ENCODER_LI_EN
  localparam int unsigned MAX_LEGAL = 11;
`else
  localparam int unsigned MAX_LEGAL = 10;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_instr_encoder_if #(.DEPTH(DEPTH)) enc_if();
  mips_instr_encoder #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .enc(enc_if));

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model: expected FIFO contents, pending LI low half, sticky error, expected ready
  int unsigned mq[$];
  bit          m_li_pend = 1'b0;
  int unsigned m_li_word = 0;
  bit          m_err     = 1'b0;
  bit          m_ready   = 1'b1;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int unsigned itype(int unsigned op, int unsigned rs, int unsigned rt,
                                        int unsigned imm);
    return op * P26 + rs * P21 + rt * P16 + (imm % P16);
  endfunction

  function automatic int unsigned ref_word(int unsigned code, int unsigned rs, int unsigned rt,
                                           int unsigned rd, int unsigned imm);
    case (code)
      1:  return rs * P21 + rt * P16 + rd * P11 + 32'h21;
      2:  return rs * P21 + rt * P16 + rd * P11 + 32'h23;
      3:  return itype(32'h0D, rs, rt, imm);
      4:  return itype(32'h23, rs, rt, imm);
      5:  return itype(32'h2B, rs, rt, imm);
      6:  return itype(32'h04, rs, rt, imm);
      7:  return itype(32'h0F, 0, rt, imm);
      8:  return 32'h02 * P26 + (imm % P26);
      9:  return 32'h03 * P26 + (imm % P26);
      10: return rs * P21 + 32'h08;
      default: return 0;
    endcase
  endfunction

  task automatic set_cmd(bit v, int unsigned code, int unsigned rs, int unsigned rt,
                         int unsigned rd, int unsigned imm);
    enc_if.cmd_valid = v;
    enc_if.cmd_code  = code[3:0];
    enc_if.cmd_rs    = rs[4:0];
    enc_if.cmd_rt    = rt[4:0];
    enc_if.cmd_rd    = rd[4:0];
    enc_if.cmd_imm   = imm;
  endtask

  task automatic check_outputs(string tag);
    int unsigned head;
    check_eq({tag, ".valid"}, enc_if.instr_valid, (mq.size() != 0));
    check_eq({tag, ".count"}, enc_if.count, mq.size());
    check_eq({tag, ".ready"}, enc_if.cmd_ready, m_ready);
    check_eq({tag, ".err"},   enc_if.err, m_err);
    head = (mq.size() != 0) ? mq[0] : 0;
    check_eq({tag, ".instr"}, enc_if.instr, head);
    check_eq({tag, ".op"},    enc_if.op, head / P26);
    check_eq({tag, ".fun"},   enc_if.fun, head % 64);
  endtask

  // Advance one clock: update the model from the currently driven inputs, then check
  task automatic step(string tag);
    bit          pop;
    bit          acc;
    bit          do_push;
    int unsigned code, rs, rt, rd, imm, w;
    pop     = (mq.size() != 0) && (enc_if.instr_ready === 1'b1);
    acc     = (enc_if.cmd_valid === 1'b1) && m_ready;
    code    = enc_if.cmd_code;
    rs      = enc_if.cmd_rs;
    rt      = enc_if.cmd_rt;
    rd      = enc_if.cmd_rd;
    imm     = enc_if.cmd_imm;
    do_push = 1'b0;
    w       = 0;
    if (reset) begin
      mq.delete();
      m_li_pend = 1'b0;
      m_err     = 1'b0;
    end else begin
      if (m_li_pend) begin
        if (mq.size() < DEPTH) begin
          do_push   = 1'b1;
          w         = m_li_word;
          m_li_pend = 1'b0;
        end
      end else if (acc) begin
        if (code > MAX_LEGAL) begin
          m_err = 1'b1;
        end else if (code == 11) begin
          do_push   = 1'b1;
          w         = itype(32'h0F, 0, rt, imm / P16);
          m_li_word = itype(32'h0D, rt, rt, imm % P16);
          m_li_pend = 1'b1;
        end else begin
          do_push = 1'b1;
          w       = ref_word(code, rs, rt, rd, imm);
        end
      end
      if (pop) void'(mq.pop_front());
      if (do_push) mq.push_back(w);
    end
    m_ready = !m_li_pend && (mq.size() < DEPTH);
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    set_cmd(1'b0, 0, 0, 0, 0, 0);
    enc_if.instr_ready = 1'b0;

    // Reset state
    reset = 1'b1;
    step("reset");
    check_eq("reset.ready_one", enc_if.cmd_ready, 1'b1);
    reset = 1'b0;

    // ADDU rs=1 rt=2 rd=3
    enc_if.instr_ready = 1'b1;
    set_cmd(1'b1, 1, 1, 2, 3, 0);
    step("addu");
    check_eq("addu.word", enc_if.instr, 32'h00221821);
    check_eq("addu.fun",  enc_if.fun, 6'h21);
    set_cmd(1'b0, 0, 0, 0, 0, 0);
    step("addu.drain");
    check_eq("addu.count0", enc_if.count, 0);

`ifdef ENCODER_LI_EN
    // LI rt=8 imm=0x12345678 expands to LUI then ORI, ready low one cycle
    set_cmd(1'b1, 11, 0, 8, 0, 32'h12345678);
    step("li.hi");
    check_eq("li.hi.word", enc_if.instr, 32'h3C081234);
    check_eq("li.ready_low", enc_if.cmd_ready, 1'b0);
    set_cmd(1'b0, 0, 0, 0, 0, 0);
    step("li.lo");
    check_eq("li.lo.word", enc_if.instr, 32'h35085678);
    check_eq("li.ready_back", enc_if.cmd_ready, 1'b1);
    step("li.drain");
`else
    // LI is illegal in this build
    set_cmd(1'b1, 11, 0, 8, 0, 32'h12345678);
    step("li_off");
    check_eq("li_off.err", enc_if.err, 1'b1);
    check_eq("li_off.count", enc_if.count, 0);
    set_cmd(1'b0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step("li_off.reset");
    reset = 1'b0;
`endif

    // Fill with four ORIs under backpressure, then drain in order
    enc_if.instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_cmd(1'b1, 3, i, i + 4, 0, 32'h100 + i);
      step("fill");
    end
    check_eq("fill.count4", enc_if.count, 4);
    check_eq("fill.ready0", enc_if.cmd_ready, 1'b0);
    set_cmd(1'b1, 1, 7, 7, 7, 0);
    step("fill.blocked");
    set_cmd(1'b0, 0, 0, 0, 0, 0);
    enc_if.instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step("drain");
      check_eq("drain.count", enc_if.count, 3 - i);
    end

    // Illegal code then JR rs=31
    set_cmd(1'b1, 13, 1, 2, 3, 32'hFFFF);
    step("illegal");
    check_eq("illegal.err", enc_if.err, 1'b1);
    check_eq("illegal.count", enc_if.count, 0);
    set_cmd(1'b1, 10, 31, 0, 0, 0);
    step("jr");
    check_eq("jr.word", enc_if.instr, 32'h03E00008);
    check_eq("jr.err_sticky", enc_if.err, 1'b1);
    set_cmd(1'b0, 0, 0, 0, 0, 0);
    step("jr.drain");

`ifdef ENCODER_LI_EN
    // Reset while the ORI half is pending discards it
    reset = 1'b1;
    step("li_rst.pre");
    reset = 1'b0;
    enc_if.instr_ready = 1'b0;
    set_cmd(1'b1, 11, 0, 8, 0, 32'h12345678);
    step("li_rst.hi");
    set_cmd(1'b0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step("li_rst.reset");
    check_eq("li_rst.count0", enc_if.count, 0);
    check_eq("li_rst.idle", enc_if.cmd_ready, 1'b1);
    reset = 1'b0;
    enc_if.instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("li_rst.after");
      check_eq("li_rst.no_ori", enc_if.instr_valid, 1'b0);
    end
`endif

    // Randomized traffic
    reset = 1'b1;
    step("rand.reset");
    reset = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      set_cmd(($urandom % 10) < 7, $urandom % 16, $urandom % 32, $urandom % 32,
              $urandom % 32, $urandom);
      enc_if.instr_ready = ($urandom % 10) < 6;
      reset = ($urandom % 200) == 0;
      step("rand");
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
